// File: rtl/sd_pkg.sv
// Shared definitions for the SD block-fetch path.
// - FSM state encodings (3-bit) used by sd_block_fetch_ctrl.
// - SD block size in bytes.
// - MMIO register addresses of the CPU-facing SD interface.
package sd_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_WAIT_READY = 3'd1;
  localparam state_t ST_ISSUE      = 3'd2;
  localparam state_t ST_RECV       = 3'd3;
  localparam state_t ST_DONE       = 3'd4;
  localparam state_t ST_ERR        = 3'd5;

  localparam int SD_BLOCK_BYTES = 512;

  localparam logic [31:0] SD_INTERFACE_ADDR = 32'h0000_FF00;
  localparam logic [31:0] SD_INTERFACE_DATA = 32'h0000_FF04;
  localparam logic [31:0] SD_INTERFACE_CTRL = 32'h0000_FF08;

endpackage

// File: rtl/sd_block_fetch_ctrl_if.sv
// Handshake bundle between the block-fetch controller and the SPI SD core.
//   sd_ready          core -> ctrl  core idle (1) / busy (0)
//   sd_rd             ctrl -> core  read request
//   sd_address        ctrl -> core  block address
//   sd_dout           core -> ctrl  streamed byte
//   sd_byte_available core -> ctrl  byte-valid level
// master = controller side, slave = SD core side.
interface sd_block_fetch_ctrl_if;

  logic        sd_ready;
  logic        sd_rd;
  logic [31:0] sd_address;
  logic [7:0]  sd_dout;
  logic        sd_byte_available;

  modport master (
    input  sd_ready,
    input  sd_dout,
    input  sd_byte_available,
    output sd_rd,
    output sd_address
  );

  modport slave (
    output sd_ready,
    output sd_dout,
    output sd_byte_available,
    input  sd_rd,
    input  sd_address
  );

endinterface

// File: rtl/sd_block_buffer.sv
// Local block buffer: simple dual-port RAM, one write port and one
// synchronous read port (1-cycle latency), DEPTH x 8.
//   clk, rst        clock / async active-high reset (read register only)
//   we, waddr, wdata write port
//   raddr, rdata    read port; a same-address write returns the old byte
module sd_block_buffer #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];
  logic [7:0] rdata_q, rdata_d;

  // Contents are not reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = mem[raddr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= 8'h00;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sd_block_fetch_ctrl.sv
// Single-block read sequencer between the MMIO SD registers and the SPI SD core.
// Accepts a block address, waits for the core to be idle, pulses the read
// request, and stores the streamed bytes in a local buffer.
//   iCLK, Reset         clock / async active-high reset
//   req_valid/addr      CPU request strobe + block address; req_ready = !busy
//   sd                  SD core handshake (master side)
//   buf_rd_addr/data    CPU buffer read port, 1-cycle latency
//   busy, done, error   status; done/error sticky until next accepted request
//   byte_count          bytes received in current/last transfer
module sd_block_fetch_ctrl
  import sd_pkg::*;
#(
  parameter int BLOCK_BYTES = SD_BLOCK_BYTES,
  parameter int CNT_W       = 10,
  parameter int BUF_AW      = 9,
  parameter int TIMEOUT_CYC = 2**20
) (
  input  logic                iCLK,
  input  logic                Reset,
  input  logic                req_valid,
  input  logic [31:0]         req_addr,
  output logic                req_ready,
  sd_block_fetch_ctrl_if.master sd,
  input  logic [BUF_AW-1:0]   buf_rd_addr,
  output logic [7:0]          buf_rd_data,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [CNT_W-1:0]    byte_count
);

  localparam int                TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(BLOCK_BYTES - 1);

  state_t             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               avail_prev_q, avail_prev_d;

  logic accept;
  logic take;
  logic tmo_hit;
  logic last_byte;

  assign accept    = req_valid && req_ready;
  // A byte is taken only on a rising edge of the byte-valid level.
  assign take      = (state_q == ST_RECV) && sd.sd_byte_available && !avail_prev_q;
  assign tmo_hit   = (tmo_q == TMO_MAX);
  assign last_byte = (cnt_q == LAST_IDX);

  // State register
  always_ff @(posedge iCLK or posedge Reset) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (req_valid) state_d = ST_WAIT_READY;
      end
      ST_WAIT_READY: begin
        if (sd.sd_ready)  state_d = ST_ISSUE;
        else if (tmo_hit) state_d = ST_ERR;
      end
      ST_ISSUE: begin
        if (!sd.sd_ready) state_d = ST_RECV;
      end
      ST_RECV: begin
        if (take && last_byte)  state_d = ST_DONE;
        else if (!take && tmo_hit) state_d = ST_ERR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic (Moore, decoded from state; sd_rd drops with async reset)
  always_comb begin
    sd.sd_rd  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    case (state_q)
      ST_WAIT_READY: busy = 1'b1;
      ST_ISSUE: begin
        busy     = 1'b1;
        sd.sd_rd = 1'b1;
      end
      ST_RECV:  busy  = 1'b1;
      ST_DONE:  done  = 1'b1;
      ST_ERR:   error = 1'b1;
      default: ;
    endcase
    req_ready = !busy;
  end

  // Address latch, byte counter, timeout counter and edge detector
  always_comb begin
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    avail_prev_d = sd.sd_byte_available;

    if (accept) begin
      addr_d = req_addr;
      cnt_d  = '0;
      tmo_d  = '0;
    end

    case (state_q)
      ST_WAIT_READY: begin
        if (!tmo_hit) tmo_d = tmo_q + TMO_W'(1);
      end
      ST_ISSUE: begin
        tmo_d        = '0;
        // Prime the detector so a level already high on entry is not a byte.
        avail_prev_d = 1'b1;
      end
      ST_RECV: begin
        if (take) begin
          cnt_d = cnt_q + CNT_W'(1);
          tmo_d = '0;
        end else if (!tmo_hit) begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge iCLK or posedge Reset) begin
    if (Reset) begin
      addr_q       <= '0;
      cnt_q        <= '0;
      tmo_q        <= '0;
      avail_prev_q <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      avail_prev_q <= avail_prev_d;
    end
  end

  assign sd.sd_address = addr_q;
  assign byte_count    = cnt_q;

  sd_block_buffer #(
    .DEPTH (BLOCK_BYTES),
    .AW    (BUF_AW)
  ) u_buf (
    .clk   (iCLK),
    .rst   (Reset),
    .we    (take),
    .waddr (cnt_q[BUF_AW-1:0]),
    .wdata (sd.sd_dout),
    .raddr (buf_rd_addr),
    .rdata (buf_rd_data)
  );

endmodule

// File: tb/tb_sd_block_fetch_ctrl.sv
// Bench for sd_block_fetch_ctrl: directed transfers against a small SD core
// model; completion status and buffer reads are checked from scoreboards.
`timescale 1ns/1ps
module tb_sd_block_fetch_ctrl;

  localparam int CNT_W       = 10;
  localparam int BUF_AW      = 9;
  localparam int TIMEOUT_CYC = 64;

  logic              iCLK = 1'b0;
  logic              Reset = 1'b1;
  logic              req_valid = 1'b0;
  logic [31:0]       req_addr = 32'h0;
  logic              req_ready;
  logic [BUF_AW-1:0] buf_rd_addr = '0;
  logic [7:0]        buf_rd_data;
  logic              busy, done, error;
  logic [CNT_W-1:0]  byte_count;

  sd_block_fetch_ctrl_if sd ();

  always #5 iCLK = ~iCLK;

  sd_block_fetch_ctrl #(
    .BLOCK_BYTES (512),
    .CNT_W       (CNT_W),
    .BUF_AW      (BUF_AW),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .iCLK        (iCLK),
    .Reset       (Reset),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .sd          (sd.master),
    .buf_rd_addr (buf_rd_addr),
    .buf_rd_data (buf_rd_data),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .byte_count  (byte_count)
  );

  typedef struct {
    string            tag;
    logic             done;
    logic             error;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      addr;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] rd_q[$];
  int         n_pass  = 0;
  int         n_total = 0;
  bit         rd_vld = 1'b0;
  bit         rd_vld_p = 1'b0;
  bit         abort_core = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge iCLK);
      #1;
    end
  endtask

  task automatic push_exp(input string tag, input logic d, input logic e,
                          input logic [CNT_W-1:0] c, input logic [31:0] a);
    exp_t x;
    x.tag = tag; x.done = d; x.error = e; x.cnt = c; x.addr = a;
    exp_q.push_back(x);
  endtask

  task automatic issue_req(input logic [31:0] a);
    req_addr  = a;
    req_valid = 1'b1;
    cyc(1);
    req_valid = 1'b0;
  endtask

  task automatic read_buf(input logic [BUF_AW-1:0] a, input logic [7:0] e);
    buf_rd_addr = a;
    rd_q.push_back(e);
    rd_vld = 1'b1;
    cyc(1);
    rd_vld = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int k = 0;
    while (busy && k < budget) begin cyc(1); k++; end
    chk({nm, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_count(input string nm, input int n, input int budget);
    int k = 0;
    while (int'(byte_count) < n && k < budget) begin cyc(1); k++; end
    chk({nm, "_count_reached"}, 32'(int'(byte_count) >= n), 32'd1);
  endtask

  // SD core model: waits for sd_rd, acks after 'ack' cycles, streams n bytes
  // (byte i = i ^ key, extras beyond 512 are 0xEE), each held 'hi' cycles.
  // 'pre' raises the byte-valid level on the first RECV cycle before streaming.
  task automatic core_model(input int n, input logic [7:0] key, input int hi,
                            input int ack, input bit pre);
    int k = 0;
    while (!sd.sd_rd && k < 300) begin cyc(1); k++; end
    if (!sd.sd_rd) return;
    cyc(ack);
    sd.sd_ready = 1'b0;
    cyc(1);
    if (pre) begin
      sd.sd_dout = 8'hEE;
      sd.sd_byte_available = 1'b1;
      cyc(3);
      sd.sd_byte_available = 1'b0;
    end
    cyc(2);
    for (int i = 0; i < n && !abort_core; i++) begin
      sd.sd_dout = (i < 512) ? (8'(i) ^ key) : 8'hEE;
      sd.sd_byte_available = 1'b1;
      cyc(hi);
      sd.sd_byte_available = 1'b0;
      cyc(2);
    end
    sd.sd_byte_available = 1'b0;
    sd.sd_ready = 1'b1;
  endtask

  always @(posedge iCLK) rd_vld_p <= rd_vld;

  // Monitor: buffer read data one cycle after a read, and status on each
  // busy 1->0 transition outside reset.
  initial begin
    exp_t x;
    logic [7:0] e;
    bit busy_prev;
    busy_prev = 1'b0;
    forever begin
      @(negedge iCLK);
      if (rd_vld_p) begin
        if (rd_q.size() == 0) begin
          n_total++;
          $display("FAIL rd_scoreboard: read data with no expected byte");
        end else begin
          e = rd_q.pop_front();
          chk($sformatf("buf_rd_data[%0d]", buf_rd_addr), 32'(buf_rd_data), 32'(e));
        end
      end
      if (!Reset && busy_prev && !busy) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL done_scoreboard: completion with no expected transfer");
        end else begin
          x = exp_q.pop_front();
          chk({x.tag, "_done"},       32'(done),       32'(x.done));
          chk({x.tag, "_error"},      32'(error),      32'(x.error));
          chk({x.tag, "_byte_count"}, 32'(byte_count), 32'(x.cnt));
          chk({x.tag, "_sd_address"}, sd.sd_address,   x.addr);
        end
      end
      busy_prev = busy;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    sd.sd_ready = 1'b1;
    sd.sd_dout = 8'h00;
    sd.sd_byte_available = 1'b0;

    // Reset values
    #23;
    chk("rst_busy",       32'(busy),        32'd0);
    chk("rst_done",       32'(done),        32'd0);
    chk("rst_error",      32'(error),       32'd0);
    chk("rst_byte_count", 32'(byte_count),  32'd0);
    chk("rst_sd_rd",      32'(sd.sd_rd),    32'd0);
    chk("rst_sd_address", sd.sd_address,    32'd0);
    chk("rst_req_ready",  32'(req_ready),   32'd1);
    chk("rst_buf_rd",     32'(buf_rd_data), 32'd0);
    @(posedge iCLK); #1;
    Reset = 1'b0;
    cyc(2);

    // 1) Basic 512-byte transfer, core acks after 3 cycles
    push_exp("t1", 1'b1, 1'b0, 10'd512, 32'h10);
    fork
      core_model(512, 8'h00, 1, 3, 1'b0);
      begin
        issue_req(32'h0000_0010);
        n = 0;
        while (!sd.sd_rd && n < 20) begin cyc(1); n++; end
        n = 0;
        while (sd.sd_rd && n < 50) begin n++; cyc(1); end
        chk("t1_sd_rd_high_cycles", 32'(n), 32'd4);
        chk("t1_sd_address", sd.sd_address, 32'h10);
        wait_idle("t1", 3000);
      end
    join
    read_buf(9'd0,   8'h00);
    read_buf(9'd511, 8'hFF);
    read_buf(9'd300, 8'h2C);

    // 2) Core busy for 50 cycles after the request
    sd.sd_ready = 1'b0;
    push_exp("t2", 1'b1, 1'b0, 10'd512, 32'h20);
    fork
      core_model(512, 8'h11, 1, 0, 1'b0);
      begin
        issue_req(32'h0000_0020);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
          cyc(1);
          if (sd.sd_rd) bad++;
        end
        chk("t2_sd_rd_low_while_busy", 32'(bad), 32'd0);
        chk("t2_busy_waiting", 32'(busy), 32'd1);
        sd.sd_ready = 1'b1;
        cyc(1);
        chk("t2_sd_rd_asserts", 32'(sd.sd_rd), 32'd1);
        cyc(1);
        chk("t2_sd_rd_drops_after_ack", 32'(sd.sd_rd), 32'd0);
        wait_idle("t2", 3000);
      end
    join
    read_buf(9'd5, 8'h14);

    // 3) Core stops after 100 bytes -> timeout error
    push_exp("t3", 1'b0, 1'b1, 10'd100, 32'h30);
    fork
      core_model(100, 8'h00, 1, 0, 1'b0);
      issue_req(32'h0000_0030);
    join
    cyc(40);
    chk("t3_no_early_error", 32'(error), 32'd0);
    chk("t3_still_busy",     32'(busy),  32'd1);
    wait_idle("t3", 200);
    read_buf(9'd99, 8'h63);

    // 4) Request during RECV is dropped
    push_exp("t4", 1'b1, 1'b0, 10'd512, 32'h44);
    fork
      core_model(512, 8'h3C, 1, 0, 1'b0);
      begin
        issue_req(32'h0000_0044);
        wait_count("t4", 50, 2000);
        req_addr  = 32'hDEAD_BEEF;
        req_valid = 1'b1;
        cyc(1);
        req_valid = 1'b0;
        chk("t4_addr_unchanged", sd.sd_address, 32'h44);
        chk("t4_busy_kept",      32'(busy),     32'd1);
        wait_idle("t4", 3000);
      end
    join
    read_buf(9'd10, 8'h36);

    // 5) Asynchronous reset at byte 200, then a fresh transfer
    fork
      core_model(512, 8'h00, 1, 0, 1'b0);
      begin
        issue_req(32'h0000_0055);
        wait_count("t5", 200, 2000);
        #2;
        Reset = 1'b1;
        #1;
        chk("t5_async_busy",       32'(busy),       32'd0);
        chk("t5_async_sd_rd",      32'(sd.sd_rd),   32'd0);
        chk("t5_async_byte_count", 32'(byte_count), 32'd0);
        chk("t5_async_req_ready",  32'(req_ready),  32'd1);
        chk("t5_async_sd_address", sd.sd_address,   32'd0);
        abort_core = 1'b1;
        cyc(3);
        Reset = 1'b0;
      end
    join
    abort_core = 1'b0;
    cyc(2);
    push_exp("t5b", 1'b1, 1'b0, 10'd512, 32'h66);
    fork
      core_model(512, 8'h00, 1, 0, 1'b0);
      begin
        issue_req(32'h0000_0066);
        wait_idle("t5b", 3000);
      end
    join
    read_buf(9'd200, 8'hC8);

    // 6) Byte-valid held 3 cycles, level high on RECV entry, 2 extra bytes
    push_exp("t6", 1'b1, 1'b0, 10'd512, 32'h77);
    fork
      core_model(514, 8'hA5, 3, 0, 1'b1);
      begin
        issue_req(32'h0000_0077);
        wait_idle("t6", 4000);
      end
    join
    chk("t6_count_after_extras", 32'(byte_count), 32'd512);
    chk("t6_done_after_extras",  32'(done),       32'd1);
    read_buf(9'd0,   8'hA5);
    read_buf(9'd1,   8'hA4);
    read_buf(9'd511, 8'h5A);

    @(negedge iCLK); #1;
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("rd_q_drained",  32'(rd_q.size()),  32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
